// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out LSB-first with
// optional repeats and idle gaps. Define SERIAL_TX_PARITY_EN to append an even-parity bit.
module serial_pattern_tx #(
    parameter int NBITS      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int NREP_BITS  = 3
) (
    input  logic                         clk_2,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NBITS-1:0]             pattern,
    input  logic [NREP_BITS-1:0]         reps,
    output logic                         data_out,
    output logic                         valid_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NBITS+1)-1:0]   bit_idx
);

    localparam int IDXW = $clog2(NBITS+1);
`ifdef SERIAL_TX_PARITY_EN
    localparam int FLEN = NBITS + 1;
`else
    localparam int FLEN = NBITS;
`endif
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FLEN - 1);
    localparam logic [3:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                 state_q, state_d;
    logic [FLEN-1:0]        shreg_q, shreg_d;
    logic [FLEN-1:0]        pat_q, pat_d;
    logic [NREP_BITS-1:0]   rep_q, rep_d;
    logic [3:0]             gap_q, gap_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [FLEN-1:0]        frame;

`ifdef SERIAL_TX_PARITY_EN
    assign frame = {^pattern, pattern};
`else
    assign frame = pattern;
`endif

    // The shift register is kept at zero outside of frame bits, so its LSB
    // doubles as the registered data_out.
    always_comb begin
        state_d = state_q;
        shreg_d = '0;
        pat_d   = pat_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        idx_d   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = frame;
                    shreg_d = frame;
                    rep_d   = (reps == '0) ? NREP_BITS'(1) : reps;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    rep_d = rep_q - 1'b1;
                    if (rep_q == NREP_BITS'(1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        shreg_d = pat_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    shreg_d = shreg_q >> 1;
                    valid_d = 1'b1;
                    idx_d   = idx_q + 1'b1;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_q == 4'd0) begin
                    shreg_d = pat_q;
                    valid_d = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign data_out  = shreg_q[0];
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_idx   = idx_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one instance with a 1-cycle gap and one
// with back-to-back frames, both driven from the same stimulus.
module tb_serial_pattern_tx;

    localparam int NBITS = 4;
    localparam int IDXW  = 3;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FLEN = NBITS + 1;
`else
    localparam int FLEN = NBITS;
`endif

    logic            clk_2 = 1'b0;
    logic            reset;
    logic            start;
    logic [3:0]      pattern;
    logic [2:0]      reps;

    logic            g_data, g_valid, g_busy, g_done;
    logic [IDXW-1:0] g_idx;
    logic            z_data, z_valid, z_busy, z_done;
    logic [IDXW-1:0] z_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_2 = ~clk_2;

    serial_pattern_tx #(.NBITS(NBITS), .GAP_CYCLES(1), .NREP_BITS(3)) dut (
        .clk_2(clk_2), .reset(reset), .start(start), .pattern(pattern), .reps(reps),
        .data_out(g_data), .valid_out(g_valid), .busy(g_busy), .done(g_done), .bit_idx(g_idx)
    );

    serial_pattern_tx #(.NBITS(NBITS), .GAP_CYCLES(0), .NREP_BITS(3)) dut0 (
        .clk_2(clk_2), .reset(reset), .start(start), .pattern(pattern), .reps(reps),
        .data_out(z_data), .valid_out(z_valid), .busy(z_busy), .done(z_done), .bit_idx(z_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // sel 0 = gap instance, sel 1 = back-to-back instance
    task automatic expect_out(input int sel, input string tag, input logic d, input logic v,
                              input logic b, input logic dn, input int idx);
        logic dd, vv, bb, nn;
        logic [IDXW-1:0] ii;
        if (sel == 0) begin
            dd = g_data; vv = g_valid; bb = g_busy; nn = g_done; ii = g_idx;
        end else begin
            dd = z_data; vv = z_valid; bb = z_busy; nn = z_done; ii = z_idx;
        end
        check($sformatf("%s.data", tag),  32'(dd), 32'(d));
        check($sformatf("%s.valid", tag), 32'(vv), 32'(v));
        check($sformatf("%s.busy", tag),  32'(bb), 32'(b));
        check($sformatf("%s.done", tag),  32'(nn), 32'(dn));
        check($sformatf("%s.idx", tag),   32'(ii), 32'(idx));
    endtask

    // Checks frame bits from index 'first' onward, advancing one clock per bit.
    task automatic send_frame(input int sel, input string tag, input logic [3:0] pat, input int first);
        logic b;
        for (int i = first; i < FLEN; i++) begin
            b = (i < NBITS) ? pat[i] : ^pat;
            expect_out(sel, $sformatf("%s.b%0d", tag, i), b, 1'b1, 1'b1, 1'b0, i);
            tick();
        end
    endtask

    task automatic pulse_start(input logic [3:0] pat, input logic [2:0] r);
        pattern = pat;
        reps    = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        pattern = 4'b0000;
        reps    = 3'd0;

        // Test 1: reset state, single frame of 1101
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out(0, $sformatf("rst%0d", i), 0, 0, 0, 0, 0);
        end
        reset = 1'b1;
        tick();
        expect_out(0, "idle0", 0, 0, 0, 0, 0);
        pulse_start(4'b1101, 3'd1);
        send_frame(0, "t1", 4'b1101, 0);
        expect_out(0, "t1.done", 0, 0, 1, 1, 0);
        tick();
        expect_out(0, "t1.idle", 0, 0, 0, 0, 0);
        tick();
        expect_out(0, "t1.idle2", 0, 0, 0, 0, 0);
        settle(16);

        // Test 2: three frames separated by one gap cycle
        pulse_start(4'b1101, 3'd3);
        send_frame(0, "t2f0", 4'b1101, 0);
        expect_out(0, "t2.gap0", 0, 0, 1, 0, 0);
        tick();
        send_frame(0, "t2f1", 4'b1101, 0);
        expect_out(0, "t2.gap1", 0, 0, 1, 0, 0);
        tick();
        send_frame(0, "t2f2", 4'b1101, 0);
        expect_out(0, "t2.done", 0, 0, 1, 1, 0);
        tick();
        expect_out(0, "t2.idle", 0, 0, 0, 0, 0);
        settle(16);

        // Test 3: back-to-back frames on the zero-gap instance
        pulse_start(4'b0110, 3'd2);
        send_frame(1, "t3f0", 4'b0110, 0);
        send_frame(1, "t3f1", 4'b0110, 0);
        expect_out(1, "t3.done", 0, 0, 1, 1, 0);
        tick();
        expect_out(1, "t3.idle", 0, 0, 0, 0, 0);
        settle(16);

        // Test 4: reps=0 sends exactly one frame
        pulse_start(4'b1111, 3'd0);
        send_frame(0, "t4", 4'b1111, 0);
        expect_out(0, "t4.done", 0, 0, 1, 1, 0);
        tick();
        expect_out(0, "t4.idle", 0, 0, 0, 0, 0);
        settle(16);

        // Test 5: asynchronous reset during the third bit
        pulse_start(4'b1101, 3'd1);
        send_frame(0, "t5pre", 4'b1101, 0);
        settle(20);
        pulse_start(4'b1101, 3'd1);
        tick();
        tick();
        expect_out(0, "t5.b2", 1, 1, 1, 0, 2);
        #2 reset = 1'b0;
        #1;
        expect_out(0, "t5.abort", 0, 0, 0, 0, 0);
        expect_out(1, "t5.abort0", 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out(0, $sformatf("t5.quiet%0d", i), 0, 0, 0, 0, 0);
        end
        pulse_start(4'b1101, 3'd1);
        send_frame(0, "t5fresh", 4'b1101, 0);
        expect_out(0, "t5.done", 0, 0, 1, 1, 0);
        tick();
        settle(16);

        // Test 6: start and pattern/reps changes mid-frame are ignored
        pulse_start(4'b1101, 3'd1);
        send_frame(0, "t6a", 4'b1101, 0);
        settle(20);
        pulse_start(4'b1101, 3'd1);
        expect_out(0, "t6.b0", 1, 1, 1, 0, 0);
        pattern = 4'b0000;
        reps    = 3'd5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        send_frame(0, "t6b", 4'b1101, 1);
        expect_out(0, "t6.done", 0, 0, 1, 1, 0);
        tick();
        expect_out(0, "t6.idle", 0, 0, 0, 0, 0);
        settle(16);

        // Start held high: exactly one idle cycle between transfers
        pattern = 4'b1101;
        reps    = 3'd1;
        start   = 1'b1;
        tick();
        send_frame(0, "th0", 4'b1101, 0);
        expect_out(0, "th.done", 0, 0, 1, 1, 0);
        tick();
        expect_out(0, "th.idle", 0, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        send_frame(0, "th1", 4'b1101, 0);
        expect_out(0, "th.done2", 0, 0, 1, 1, 0);
        settle(20);
        expect_out(0, "end", 0, 0, 0, 0, 0);
        expect_out(1, "end0", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
